// File: rtl/mp_alu_seq_if.sv
// Bundle between the multi-precision sequencer and its environment:
// request/status from the decoder, the data-memory port and the 8-bit ALU port.
interface mp_alu_seq_if #(
  parameter int MAX_LEN = 8,
  parameter int AW      = 8
);
  localparam int LW = $clog2(MAX_LEN) + 1;

  logic          start;
  logic [3:0]    op;
  logic [LW-1:0] len;
  logic [AW-1:0] a_base, b_base, d_base;

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  logic [3:0]    alu_op;
  logic [7:0]    alu_acc, alu_in;
  logic          alu_sc_in, alu_reg_exe;
  logic [7:0]    alu_out;
  logic          alu_sc_out;

  logic          busy, done, err, carry_out, zero;

  modport master (
    input  start, op, len, a_base, b_base, d_base, mem_rd_data, alu_out, alu_sc_out,
    output mem_addr, mem_wr_en, mem_wr_data, alu_op, alu_acc, alu_in, alu_sc_in,
           alu_reg_exe, busy, done, err, carry_out, zero
  );

  modport slave (
    output start, op, len, a_base, b_base, d_base, mem_rd_data, alu_out, alu_sc_out,
    input  mem_addr, mem_wr_en, mem_wr_data, alu_op, alu_acc, alu_in, alu_sc_in,
           alu_reg_exe, busy, done, err, carry_out, zero
  );
endinterface

// File: rtl/mp_alu_seq.sv
// Multi-precision ADD/SUB/SL/SR sequencer: walks operands one byte per pass
// through an external 8-bit ALU, chaining carry/shift bits between bytes.
module mp_alu_seq #(
  parameter int       MAX_LEN = 8,
  parameter int       AW      = 8,
  parameter bit [3:0] OP_ADD  = 4'h0,
  parameter bit [3:0] OP_SUB  = 4'h1,
  parameter bit [3:0] OP_SL   = 4'h3,
  parameter bit [3:0] OP_SR   = 4'h4
) (
  input  logic         CLK,
  input  logic         Reset,
  mp_alu_seq_if.master bus
);
  localparam int LW = $clog2(MAX_LEN) + 1;

  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, CAPTURE, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    op_r;
  logic [LW-1:0] len_r, idx, len_clamp;
  logic [AW-1:0] a_r, b_r, d_r;
  logic [7:0]    a_reg, b_reg;
  logic          carry_r, zacc;
  logic          legal, arith, is_sr, last, accept;

  assign legal     = (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                     (bus.op == OP_SL)  || (bus.op == OP_SR);
  assign len_clamp = (bus.len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.len;
  assign arith     = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign is_sr     = (op_r == OP_SR);
  assign last      = is_sr ? (idx == '0) : (idx == len_r - LW'(1));
  assign accept    = (state == IDLE) && bus.start && legal;

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (len_clamp == '0) ? DONE : FETCH_A;
      FETCH_A: state_nxt = arith ? FETCH_B : CAPTURE;
      FETCH_B: state_nxt = CAPTURE;
      CAPTURE: state_nxt = WRITE;
      WRITE:   state_nxt = last ? DONE : FETCH_A;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = 8'h00;
    bus.alu_op      = OP_ADD;
    bus.alu_acc     = 8'h00;
    bus.alu_in      = 8'h00;
    bus.alu_sc_in   = 1'b0;
    bus.alu_reg_exe = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.err         = (state == IDLE) && bus.start && !legal && !Reset;
    unique case (state)
      FETCH_A: begin
        bus.busy     = 1'b1;
        bus.mem_addr = a_r + AW'(idx);
      end
      FETCH_B: begin
        bus.busy     = 1'b1;
        bus.mem_addr = b_r + AW'(idx);
      end
      CAPTURE: bus.busy = 1'b1;
      WRITE: begin
        bus.busy        = 1'b1;
        bus.alu_op      = op_r;
        bus.alu_acc     = a_reg;
        bus.alu_in      = b_reg;
        bus.alu_sc_in   = carry_r;
        bus.alu_reg_exe = 1'b1;
        // Gated so a reset landing on a write cycle never reaches memory.
        bus.mem_wr_en   = !Reset;
        bus.mem_addr    = d_r + AW'(idx);
        bus.mem_wr_data = bus.alu_out;
      end
      DONE:    bus.done = !Reset;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      op_r <= OP_ADD; len_r <= '0; idx <= '0;
      a_r <= '0; b_r <= '0; d_r <= '0;
      a_reg <= 8'h00; b_reg <= 8'h00;
      carry_r <= 1'b0; zacc <= 1'b0;
      bus.carry_out <= 1'b0; bus.zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_r    <= bus.op;
          len_r   <= len_clamp;
          a_r     <= bus.a_base;
          b_r     <= bus.b_base;
          d_r     <= bus.d_base;
          // Zero-length SUB has no byte to consume the borrow-in, so report 0.
          carry_r <= (bus.op == OP_SUB) && (len_clamp != '0);
          zacc    <= 1'b1;
          idx     <= (bus.op == OP_SR) ? len_clamp - LW'(1) : '0;
        end
        FETCH_B: a_reg <= bus.mem_rd_data;
        CAPTURE: if (arith) b_reg <= bus.mem_rd_data;
                 else       a_reg <= bus.mem_rd_data;
        WRITE: begin
          carry_r <= bus.alu_sc_out;
          zacc    <= zacc & (bus.alu_out == 8'h00);
          if (!last) idx <= is_sr ? idx - LW'(1) : idx + LW'(1);
        end
        DONE: begin
          bus.carry_out <= carry_r;
          bus.zero      <= zacc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq: behavioural memory + ALU, integer-level reference model.
module tb_mp_alu_seq;
  localparam int       MAX_LEN = 8;
  localparam int       AW      = 8;
  localparam bit [3:0] OP_ADD  = 4'h0;
  localparam bit [3:0] OP_SUB  = 4'h1;
  localparam bit [3:0] OP_SL   = 4'h3;
  localparam bit [3:0] OP_SR   = 4'h4;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  mp_alu_seq_if #(.MAX_LEN(MAX_LEN), .AW(AW)) bus ();

  mp_alu_seq #(.MAX_LEN(MAX_LEN), .AW(AW), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB),
               .OP_SL(OP_SL), .OP_SR(OP_SR)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  // Data memory with a tb load port; synchronous read.
  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
  always @(posedge CLK) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  logic [8:0] alu_s;
  always_comb begin
    alu_s = 9'h000;
    case (bus.alu_op)
      OP_ADD:  alu_s = {1'b0, bus.alu_acc} + {1'b0, bus.alu_in} + 9'(bus.alu_sc_in);
      OP_SUB:  alu_s = {1'b0, bus.alu_acc} + {1'b0, ~bus.alu_in} + 9'(bus.alu_sc_in);
      OP_SL:   alu_s = {bus.alu_acc, bus.alu_sc_in};
      OP_SR:   alu_s = {bus.alu_acc[0], bus.alu_sc_in, bus.alu_acc[7:1]};
      default: alu_s = 9'h000;
    endcase
    bus.alu_out    = alu_s[7:0];
    bus.alu_sc_out = alu_s[8];
  end

  logic [7:0] wr_q [$];
  int err_cnt = 0;
  always @(negedge CLK) begin
    if (bus.mem_wr_en) wr_q.push_back(bus.mem_addr);
    if (bus.err) err_cnt++;
  end

  task automatic poke(input logic [7:0] ad, input logic [7:0] dt);
    @(negedge CLK); ld_en = 1'b1; ld_addr = ad; ld_data = dt;
    @(posedge CLK); #1 ld_en = 1'b0;
  endtask

  // Starts an op and waits for done; optionally re-pulses start (as SUB) at cycle poke_at.
  task automatic run_op(input logic [3:0] o, input int l, input logic [7:0] a, b, d,
                        input int poke_at, output int lat);
    @(negedge CLK);
    bus.op = o; bus.len = 4'(l); bus.a_base = a; bus.b_base = b; bus.d_base = d;
    bus.start = 1'b1;
    lat = 0;
    do begin
      @(negedge CLK); lat++;
      bus.start = (lat == poke_at);
      if (lat == poke_at) bus.op = OP_SUB;
    end while (!bus.done && lat < 200);
    if (!bus.done) begin
      n_cmp++; n_fail++; $display("FAIL run_timeout got=no_done exp=done op=%0h len=%0d", o, l);
    end
    @(negedge CLK); bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 4'h0; bus.len = '0;
    bus.a_base = '0; bus.b_base = '0; bus.d_base = '0;
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%0b exp=0", bus.done); end
    n_cmp++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got=%0b exp=0", bus.mem_wr_en); end
    n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got=%b exp=00", {bus.carry_out, bus.zero}); end
    n_cmp++; if ({bus.mem_addr, bus.alu_acc, bus.alu_in, bus.alu_op} !== 28'h0) begin
      n_fail++; $display("FAIL rst_bus got=%h exp=0", {bus.mem_addr, bus.alu_acc, bus.alu_in, bus.alu_op}); end
    n_cmp++; if ({bus.alu_sc_in, bus.alu_reg_exe, bus.err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_ctl got=%b exp=000", {bus.alu_sc_in, bus.alu_reg_exe, bus.err}); end
    Reset = 1'b0;
  endtask

  task automatic test_add();
    int lat, w0;
    poke(8'h10, 8'hFF); poke(8'h11, 8'h01); poke(8'h20, 8'h01); poke(8'h21, 8'h00);
    poke(8'h30, 8'hAA); poke(8'h31, 8'hAA);
    w0 = wr_q.size();
    run_op(OP_ADD, 2, 8'h10, 8'h20, 8'h30, 0, lat);
    n_cmp++; if ({mem[8'h31], mem[8'h30]} !== 16'h0200) begin n_fail++; $display("FAIL add_data got=%h exp=0200", {mem[8'h31], mem[8'h30]}); end
    n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b00) begin n_fail++; $display("FAIL add_flags got=%b exp=00", {bus.carry_out, bus.zero}); end
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL add_latency got=%0d exp=9", lat); end
    n_cmp++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL add_writes got=%0d exp=2", wr_q.size() - w0); end
  endtask

  task automatic test_sub();
    int lat;
    poke(8'h10, 8'h00); poke(8'h11, 8'h00); poke(8'h20, 8'h01); poke(8'h21, 8'h00);
    run_op(OP_SUB, 2, 8'h10, 8'h20, 8'h30, 0, lat);
    n_cmp++; if ({mem[8'h31], mem[8'h30]} !== 16'hFFFF) begin n_fail++; $display("FAIL sub_borrow_data got=%h exp=ffff", {mem[8'h31], mem[8'h30]}); end
    n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b00) begin n_fail++; $display("FAIL sub_borrow_flags got=%b exp=00", {bus.carry_out, bus.zero}); end
    poke(8'h10, 8'h34); poke(8'h11, 8'h12); poke(8'h20, 8'h34); poke(8'h21, 8'h12);
    run_op(OP_SUB, 2, 8'h10, 8'h20, 8'h10, 0, lat);
    n_cmp++; if ({mem[8'h11], mem[8'h10]} !== 16'h0000) begin n_fail++; $display("FAIL sub_eq_data got=%h exp=0000", {mem[8'h11], mem[8'h10]}); end
    n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b11) begin n_fail++; $display("FAIL sub_eq_flags got=%b exp=11", {bus.carry_out, bus.zero}); end
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL sub_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_shift();
    int lat, w0;
    poke(8'h40, 8'hB3); poke(8'h41, 8'h80);
    run_op(OP_SL, 2, 8'h40, 8'h00, 8'h50, 0, lat);
    n_cmp++; if ({mem[8'h51], mem[8'h50]} !== 16'h0166) begin n_fail++; $display("FAIL sl_data got=%h exp=0166", {mem[8'h51], mem[8'h50]}); end
    n_cmp++; if (bus.carry_out !== 1'b1) begin n_fail++; $display("FAIL sl_carry got=%0b exp=1", bus.carry_out); end
    n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL sl_latency got=%0d exp=7", lat); end
    poke(8'h40, 8'h01); poke(8'h41, 8'h01);
    w0 = wr_q.size();
    run_op(OP_SR, 2, 8'h40, 8'h00, 8'h50, 0, lat);
    n_cmp++; if ({mem[8'h51], mem[8'h50]} !== 16'h0080) begin n_fail++; $display("FAIL sr_data got=%h exp=0080", {mem[8'h51], mem[8'h50]}); end
    n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b10) begin n_fail++; $display("FAIL sr_flags got=%b exp=10", {bus.carry_out, bus.zero}); end
    n_cmp++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL sr_writes got=%0d exp=2", wr_q.size() - w0); end
    else begin
      n_cmp++; if ({wr_q[w0], wr_q[w0+1]} !== 16'h5150) begin n_fail++; $display("FAIL sr_order got=%h exp=5150", {wr_q[w0], wr_q[w0+1]}); end
    end
  endtask

  task automatic test_err();
    int e0;
    e0 = err_cnt;
    @(negedge CLK); bus.op = 4'hF; bus.len = 4'd2; bus.start = 1'b1;
    #1;
    n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got=%0b exp=1", bus.err); end
    @(negedge CLK); bus.start = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL err_count got=%0d exp=1", err_cnt - e0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL err_busy got=%0b exp=0", bus.busy); end
    n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b10) begin n_fail++; $display("FAIL err_flags got=%b exp=10", {bus.carry_out, bus.zero}); end
  endtask

  task automatic test_len0();
    int lat, w0;
    w0 = wr_q.size();
    run_op(OP_ADD, 0, 8'h10, 8'h20, 8'h30, 0, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL len0_latency got=%0d exp=1", lat); end
    n_cmp++; if (wr_q.size() - w0 !== 0) begin n_fail++; $display("FAIL len0_writes got=%0d exp=0", wr_q.size() - w0); end
    n_cmp++; if ({bus.carry_out, bus.zero} !== 2'b01) begin n_fail++; $display("FAIL len0_flags got=%b exp=01", {bus.carry_out, bus.zero}); end
  endtask

  task automatic test_start_ignored();
    int lat, e0;
    e0 = err_cnt;
    poke(8'h60, 8'h80); poke(8'h61, 8'h7F); poke(8'h70, 8'h80); poke(8'h71, 8'h00);
    run_op(OP_ADD, 2, 8'h60, 8'h70, 8'h80, 3, lat);
    n_cmp++; if ({mem[8'h81], mem[8'h80]} !== 16'h8000) begin n_fail++; $display("FAIL ign_data got=%h exp=8000", {mem[8'h81], mem[8'h80]}); end
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL ign_latency got=%0d exp=9", lat); end
    run_op(OP_ADD, 2, 8'h60, 8'h70, 8'h80, 9, lat);
    @(negedge CLK);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_done_start got=%0b exp=0", bus.busy); end
    n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL ign_err got=%0d exp=%0d", err_cnt, e0); end
  endtask

  task automatic test_reset_mid();
    int lat, w0, n;
    poke(8'h90, 8'h11); poke(8'h91, 8'h22); poke(8'hA0, 8'h33); poke(8'hA1, 8'h44);
    poke(8'hB0, 8'h5A); poke(8'hB1, 8'h5A);
    @(negedge CLK);
    bus.op = OP_ADD; bus.len = 4'd2; bus.a_base = 8'h90; bus.b_base = 8'hA0; bus.d_base = 8'hB0;
    bus.start = 1'b1;
    @(negedge CLK); bus.start = 1'b0;
    n = 0;
    while (!bus.mem_wr_en && n < 20) begin @(negedge CLK); n++; end
    n_cmp++; if (bus.mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_write got=0 exp=1"); end
    w0 = wr_q.size();
    Reset = 1'b1;
    #1;
    n_cmp++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_in_reset got=%0b exp=0", bus.mem_wr_en); end
    @(negedge CLK); Reset = 1'b0;
    n_cmp++; if ({bus.busy, bus.done, bus.carry_out, bus.zero} !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_status got=%b exp=0000", {bus.busy, bus.done, bus.carry_out, bus.zero}); end
    n_cmp++; if ({bus.mem_addr, bus.alu_op, bus.alu_reg_exe} !== 13'h0) begin
      n_fail++; $display("FAIL rmid_bus got=%h exp=0", {bus.mem_addr, bus.alu_op, bus.alu_reg_exe}); end
    repeat (10) @(negedge CLK);
    n_cmp++; if (wr_q.size() !== w0 || mem[8'hB0] !== 8'h5A) begin
      n_fail++; $display("FAIL rmid_no_write got=%0d/%h exp=%0d/5a", wr_q.size(), mem[8'hB0], w0); end
    run_op(OP_ADD, 2, 8'h90, 8'hA0, 8'hB0, 0, lat);
    n_cmp++; if ({mem[8'hB1], mem[8'hB0]} !== 16'h6644 || lat !== 9) begin
      n_fail++; $display("FAIL rmid_rerun got=%h/%0d exp=6644/9", {mem[8'hB1], mem[8'hB0]}, lat); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [3:0] o;
      int l, nb, lat, w0, exp_lat;
      logic [7:0] a, b, d, ad, bt;
      logic [71:0] av, bv, full, res, mask;
      logic cexp;
      case ($urandom_range(0, 3))
        0: o = OP_ADD;
        1: o = OP_SUB;
        2: o = OP_SL;
        default: o = OP_SR;
      endcase
      l  = $urandom_range(0, 10);
      nb = (l > MAX_LEN) ? MAX_LEN : l;
      a  = 8'($urandom);
      b  = a + 8'h40;
      case ($urandom_range(0, 2))
        0: d = a + 8'h80;
        1: d = a;
        default: d = b;
      endcase
      av = '0; bv = '0;
      for (int i = 0; i < nb; i++) begin
        ad = a + 8'(i); bt = 8'($urandom); poke(ad, bt); av[8*i +: 8] = bt;
        ad = b + 8'(i); bt = 8'($urandom); poke(ad, bt); bv[8*i +: 8] = bt;
      end
      mask = (nb == 0) ? '0 : ((72'd1 << (8*nb)) - 72'd1);
      full = '0;
      if (o == OP_ADD)      full = av + bv;
      else if (o == OP_SUB) full = av + (~bv & mask) + 72'd1;
      else if (o == OP_SL)  full = av << 1;
      if (o == OP_SR) begin res = av >> 1; cexp = av[0]; end
      else            begin res = full & mask; cexp = full[8*nb]; end
      if (nb == 0) begin res = '0; cexp = 1'b0; end
      exp_lat = ((o == OP_ADD || o == OP_SUB) ? 4 : 3) * nb + 1;
      w0 = wr_q.size();
      run_op(o, l, a, b, d, 0, lat);
      for (int i = 0; i < nb; i++) begin
        ad = d + 8'(i);
        n_cmp++; if (mem[ad] !== res[8*i +: 8]) begin
          n_fail++; $display("FAIL rnd_data t=%0d op=%0h len=%0d byte=%0d got=%h exp=%h", t, o, l, i, mem[ad], res[8*i +: 8]); end
      end
      n_cmp++; if ({bus.carry_out, bus.zero} !== {cexp, (res == '0)}) begin
        n_fail++; $display("FAIL rnd_flags t=%0d op=%0h len=%0d got=%b exp=%b", t, o, l, {bus.carry_out, bus.zero}, {cexp, (res == '0)}); end
      n_cmp++; if (lat !== exp_lat) begin
        n_fail++; $display("FAIL rnd_latency t=%0d op=%0h len=%0d got=%0d exp=%0d", t, o, l, lat, exp_lat); end
      n_cmp++; if (wr_q.size() - w0 !== nb) begin
        n_fail++; $display("FAIL rnd_writes t=%0d got=%0d exp=%0d", t, wr_q.size() - w0, nb); end
      else if (nb > 0) begin
        ad = (o == OP_SR) ? d + 8'(nb - 1) : d;
        n_cmp++; if (wr_q[w0] !== ad) begin
          n_fail++; $display("FAIL rnd_first_addr t=%0d got=%h exp=%h", t, wr_q[w0], ad); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_err();
    test_len0();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mp_alu_seq.md
Name: mp_alu_seq

Overview:
- Multi-precision arithmetic sequencer. Runs a multi-byte ADD, SUB, SL or SR on the 8-bit combinational ALU, one byte per step.
- Chains SC_OUT from one byte into SC_IN of the next.
- Sits between the control decoder and the ALU/data memory. Fetches operand bytes from data memory, drives the ALU, writes result bytes back, and reports final carry and an all-zero flag.

Parameters:
- MAX_LEN, 8: maximum operand length in bytes.
- AW, 8: data-memory address width.
- OP_ADD, 4'h0: ALU opcode for add.
- OP_SUB, 4'h1: ALU opcode for subtract.
- OP_SL, 4'h3: ALU opcode for shift left.
- OP_SR, 4'h4: ALU opcode for shift right.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  4  ALU opcode; must equal one of OP_ADD/OP_SUB/OP_SL/OP_SR.
- len  input  $clog2(MAX_LEN)+1  byte count, 0..MAX_LEN.
- a_base  input  AW  base address of operand A; byte 0 = LSB.
- b_base  input  AW  base address of operand B; ignored for shifts.
- d_base  input  AW  base address of the destination.
- mem_addr  output  AW  data-memory address.
- mem_rd_data  input  8  read data; 1-cycle synchronous-read latency.
- mem_wr_en  output  1  write strobe.
- mem_wr_data  output  8  write data.
- alu_op  output  4  ALU opcode.
- alu_acc  output  8  ALU accumulator operand.
- alu_in  output  8  ALU register operand.
- alu_sc_in  output  1  ALU carry/shift in.
- alu_reg_exe  output  1  ALU register-path select.
- alu_out  input  8  ALU result.
- alu_sc_out  input  1  ALU carry/shift out.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse: start rejected, illegal op.
- carry_out  output  1  final carry of last operation.
- zero  output  1  every result byte of last operation was 0.

Behaviour:
- Reset (synchronous, active-high, also mid-operation):
  - Next cycle: state=IDLE.
  - busy, done, err, mem_wr_en, carry_out, zero, alu_sc_in, alu_reg_exe all 0.
  - mem_addr, mem_wr_data, alu_acc, alu_in all 0; alu_op=OP_ADD.
  - No write is issued in the reset cycle or after it.
- States: IDLE, FETCH_A, FETCH_B, CAPTURE, WRITE, DONE.
- IDLE, start=1 with legal op:
  - Latch op, len, a_base, b_base, d_base.
  - Carry register: 1 for SUB, 0 otherwise. Zero accumulator: 1.
  - Index: len-1 for SR, 0 otherwise.
  - len=0: go to DONE directly; carry_out=0, zero=1, no memory access.
  - Otherwise go to FETCH_A.
- IDLE, start=1 with illegal op: err=1 for one cycle, stay in IDLE, carry_out/zero unchanged.
- start while not IDLE: ignored, no err.
- busy=1 in FETCH_A, FETCH_B, CAPTURE and WRITE; 0 in IDLE and DONE.
- FETCH_A: mem_addr=a_base+idx.
  - ADD/SUB go to FETCH_B.
  - SL/SR go to CAPTURE.
- FETCH_B: a_reg<=mem_rd_data; mem_addr=b_base+idx; go to CAPTURE.
- CAPTURE:
  - ADD/SUB: b_reg<=mem_rd_data.
  - SL/SR: a_reg<=mem_rd_data.
  - Go to WRITE.
- WRITE:
  - alu_op=op, alu_acc=a_reg, alu_in=b_reg, alu_sc_in=carry reg, alu_reg_exe=1.
  - mem_wr_en=1, mem_addr=d_base+idx, mem_wr_data=alu_out.
  - carry reg<=alu_sc_out; zero acc<=zero acc & (alu_out==0).
  - Last byte (idx==len-1, or idx==0 for SR): go to DONE. Otherwise step idx (+1, or -1 for SR) and go to FETCH_A.
- Outside WRITE: alu_acc=0, alu_in=0, alu_sc_in=0, alu_reg_exe=0, mem_wr_en=0.
- DONE:
  - done=1 for one cycle.
  - carry_out<=carry reg; zero<=zero acc; both held until the next accepted start completes.
  - Go to IDLE.
  - start in the DONE cycle is ignored.
- Latency: accepted start → done high after 4·len+1 cycles for ADD/SUB, 3·len+1 for SL/SR.
- Address arithmetic wraps modulo 2^AW.
- len>MAX_LEN: treated as MAX_LEN.
- In-place operation (d_base equal to a_base or b_base) is legal: each byte is read before it is written at the same index.
- SUB semantics: A + ~B + 1 chained. carry_out=1 means no borrow.

Test Plan:
- ADD, len=2, A bytes {FF,01}, B bytes {01,00} → D bytes {00,02}; carry_out=0, zero=0; done exactly 9 cycles after start; 2 write strobes.
- SUB, len=2, A={00,00}, B={01,00} → D={FF,FF}, carry_out=0. Then SUB with A=B={34,12} → D={00,00}, carry_out=1, zero=1.
- SL, len=2, A={B3,80} → D={66,01}, carry_out=1, done 7 cycles after start. SR, len=2, A={01,01} → D={80,00}, carry_out=1; write order: high byte first.
- len=0 ADD → done next cycle, no mem_wr_en, zero=1, carry_out=0. op=4'hF → err pulse, busy stays 0, flags unchanged.
- start pulsed mid-ADD → ignored, result unchanged. Reset asserted in a WRITE cycle → IDLE next cycle, outputs at reset values, no further writes; a fresh start then completes correctly.
